// File: rtl/led_frame_pkg.sv
// Shared types and GRB word layout for the LED frame sequencer.
package led_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  localparam int PIXEL_W = 24;
  localparam int G_MSB   = 23;
  localparam int G_LSB   = 16;
  localparam int R_MSB   = 15;
  localparam int R_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 0;

  function automatic logic [PIXEL_W-1:0] pack_grb(input logic [7:0] g,
                                                  input logic [7:0] r,
                                                  input logic [7:0] b);
    logic [PIXEL_W-1:0] w;
    w = '0;
    w[G_MSB:G_LSB] = g;
    w[R_MSB:R_LSB] = r;
    w[B_MSB:B_LSB] = b;
    return w;
  endfunction

endpackage

// File: rtl/led_frame_gap_timer.sv
// Loadable down-counter; expired is the terminal-count compare against zero.
module led_frame_gap_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// Walks current_led across the strip, hands each GRB word to the serializer,
// then holds off for the strip latch gap before pulsing frame_done.
//
// state  | meaning
// S_IDLE | no frame in progress; start on update_frame or a pending request
// S_WAIT | current_led held while the display read latency elapses
// S_SEND | pixel_data offered with pixel_valid until pixel_ready accepts it
// S_GAP  | latch gap countdown after the last pixel
module led_frame_sequencer
  import led_frame_pkg::*;
#(
  parameter int MAX_POS             = 16,
  parameter int LED_READ_LATENCY    = 1,
  parameter int RESET_GAP_CLK_COUNT = 2500,
  localparam int LED_W = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               update_frame,
  output logic [LED_W-1:0]   current_led,
  input  logic [7:0]         led_green_intensity,
  input  logic [7:0]         led_red_intensity,
  input  logic [7:0]         led_blue_intensity,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               busy,
  output logic               frame_done
);

  // One counter serves both the read-latency wait and the latch gap.
  localparam int TMR_MAX = (RESET_GAP_CLK_COUNT > LED_READ_LATENCY) ?
                           RESET_GAP_CLK_COUNT : LED_READ_LATENCY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(LED_READ_LATENCY - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(RESET_GAP_CLK_COUNT - 1);
  localparam logic [LED_W-1:0] LAST_LED = LED_W'(MAX_POS - 1);

  state_e             state_q, state_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [PIXEL_W-1:0] pix_q, pix_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pending_q, pending_d;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expired;

  led_frame_gap_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    led_d     = led_q;
    pix_d     = pix_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    if (state_q != S_IDLE && update_frame) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (update_frame || pending_q) begin
          state_d   = S_WAIT;
          led_d     = '0;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LAT_LOAD;
        end
      end
      S_WAIT: begin
        if (tmr_expired) begin
          pix_d   = pack_grb(led_green_intensity, led_red_intensity, led_blue_intensity);
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (valid_q && pixel_ready) begin
          valid_d  = 1'b0;
          tmr_load = 1'b1;
          if (led_q == LAST_LED) begin
            state_d = S_GAP;
            tmr_val = GAP_LOAD;
          end else begin
            state_d = S_WAIT;
            led_d   = led_q + LED_W'(1);
            tmr_val = LAT_LOAD;
          end
        end
      end
      S_GAP: begin
        if (tmr_expired) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      led_q     <= '0;
      pix_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      pix_q     <= pix_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  assign current_led = led_q;
  assign pixel_data  = pix_q;
  assign pixel_valid = valid_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected GRB words, a negedge monitor pops them on handshake.
module tb_led_frame_sequencer;

  localparam int MP  = 4;
  localparam int LAT = 1;
  localparam int GAP = 8;
  localparam int E_LAT = 3;
  localparam int E_GAP = 1;

  typedef struct {
    int          led;
    logic [23:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst_e_n = 1'b1;
  logic upd = 1'b0;
  logic upd_e = 1'b0;
  logic rdy_man = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_bit = 1'b1;
  logic rdy_e = 1'b1;
  logic pixel_ready;

  logic [1:0]  cur;
  logic [7:0]  g, r, b;
  logic [23:0] pd;
  logic        pv, busy, fd;
  logic [7:0]  tg[MP];
  logic [7:0]  tr[MP];
  logic [7:0]  tbl_b[MP];

  logic [0:0]  cur_e;
  logic [7:0]  eg = 8'h00, er = 8'h00, eb = 8'h00;
  logic [23:0] pd_e;
  logic        pv_e, busy_e, fd_e;

  exp_t q_main[$];
  exp_t q_edge[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_main = 0, done_edge = 0;
  int exp_done_main = 0, exp_done_edge = 0;

  assign pixel_ready = rand_rdy ? rnd_bit : rdy_man;
  assign g = tg[cur];
  assign r = tr[cur];
  assign b = tbl_b[cur];

  led_frame_sequencer #(.MAX_POS(MP), .LED_READ_LATENCY(LAT), .RESET_GAP_CLK_COUNT(GAP)) dut (
    .clk(clk), .reset(rst_n), .update_frame(upd), .current_led(cur),
    .led_green_intensity(g), .led_red_intensity(r), .led_blue_intensity(b),
    .pixel_data(pd), .pixel_valid(pv), .pixel_ready(pixel_ready),
    .busy(busy), .frame_done(fd)
  );

  led_frame_sequencer #(.MAX_POS(1), .LED_READ_LATENCY(E_LAT), .RESET_GAP_CLK_COUNT(E_GAP)) dut_e (
    .clk(clk), .reset(rst_e_n), .update_frame(upd_e), .current_led(cur_e),
    .led_green_intensity(eg), .led_red_intensity(er), .led_blue_intensity(eb),
    .pixel_data(pd_e), .pixel_valid(pv_e), .pixel_ready(rdy_e),
    .busy(busy_e), .frame_done(fd_e)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && pv && pixel_ready) begin
      if (q_main.size() == 0) begin
        tests++; fails++;
        $display("FAIL main_unexpected_pixel: got led %0d data %06h, required none", cur, pd);
      end else begin
        e = q_main.pop_front();
        check("main_pixel_data", 32'(pd), 32'(e.data));
        check("main_pixel_led", 32'(cur), 32'(e.led));
      end
    end
    if (rst_e_n && pv_e && rdy_e) begin
      if (q_edge.size() == 0) begin
        tests++; fails++;
        $display("FAIL edge_unexpected_pixel: got data %06h, required none", pd_e);
      end else begin
        e = q_edge.pop_front();
        check("edge_pixel_data", 32'(pd_e), 32'(e.data));
        check("edge_pixel_led", 32'(cur_e), 32'(e.led));
      end
    end
    if (fd) done_main++;
    if (fd_e) done_edge++;
  end

  // Reference model: a frame is every strip position in order, each carrying its table entry.
  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < MP; i++) begin
      e.led  = i;
      e.data = {tg[i], tr[i], tbl_b[i]};
      q_main.push_back(e);
    end
    exp_done_main++;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return busy;
      1: return pv;
      2: return fd;
      3: return cur == 2'd2;
      4: return pv_e;
      5: return fd_e;
      7: return (cur == 2'd3) && pv;
      8: return busy && !pv;
      9: return cur == 2'd1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int bound, input string name, output int at);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < bound && !hit; n++) begin
      @(negedge clk);
      hit = sig(sel);
    end
    at = cyc;
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: got no event within %0d cycles, required event", name, bound);
    end
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cur"}, 32'(cur), 0);
    check({tag, "_data"}, 32'(pd), 0);
    check({tag, "_valid"}, 32'(pv), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(fd), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    int t0, t1, t2;
    exp_t e;
    for (int i = 0; i < MP; i++) begin
      tg[i] = 8'(i); tr[i] = 8'(8'h10 + i); tbl_b[i] = 8'hA0;
    end
    #1 rst_n = 1'b0; rst_e_n = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1; rst_e_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset_idle");

    // Basic frame with ready held high
    push_frame();
    pulse_req();
    t0 = cyc;
    check("basic_busy_rise", 32'(busy), 1);
    wait_for(1, 20, "basic_first_valid", t1);
    check("basic_req_to_valid", 32'(t1 - t0), 32'(LAT));
    wait_for(2, 200, "basic_frame_done", t2);
    check("basic_frame_len", 32'(t2 - t0), 32'(MP * (LAT + 1) + GAP));
    @(negedge clk);
    check("basic_done_one_cycle", 32'(fd), 0);
    check("basic_busy_fall", 32'(busy), 0);

    // Back-pressure on pixel 2
    push_frame();
    pulse_req();
    wait_for(3, 50, "bp_reach_led2", t1);
    #1 rdy_man = 1'b0;
    wait_for(1, 20, "bp_valid_led2", t1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(pv), 1);
      check("bp_data_held", 32'(pd), 32'h0212A0);
      check("bp_led_held", 32'(cur), 2);
      @(posedge clk); #1;
    end
    rdy_man = 1'b1;
    wait_for(2, 200, "bp_frame_done", t2);
    check("bp_queue_empty", 32'(q_main.size()), 0);

    // Pending collapse: three requests during pixel 1, one during GAP
    push_frame();
    push_frame();
    pulse_req();
    wait_for(9, 50, "pend_reach_led1", t1);
    #1 rdy_man = 1'b0;
    repeat (3) pulse_req();
    rdy_man = 1'b1;
    wait_for(7, 50, "pend_last_valid", t1);
    wait_for(8, 20, "pend_enter_gap", t1);
    pulse_req();
    wait_for(2, 200, "pend_first_done", t2);
    @(negedge clk);
    check("pend_next_start", 32'(busy), 1);
    wait_for(2, 200, "pend_second_done", t2);
    repeat (30) @(negedge clk);
    check("pend_no_third_frame", 32'(busy), 0);
    check("pend_queue_empty", 32'(q_main.size()), 0);

    // Async reset mid-SEND, with a pending request outstanding
    push_frame();
    pulse_req();
    wait_for(3, 50, "rst_reach_led2", t1);
    #1 rdy_man = 1'b0;
    pulse_req();
    wait_for(1, 20, "rst_valid_led2", t1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    q_main.delete();
    exp_done_main--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_man = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_stays_idle_busy", 32'(busy), 0);
    check("rst_stays_idle_valid", 32'(pv), 0);

    // Randomized frames with random back-pressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < MP; i++) begin
        tg[i] = 8'($urandom); tr[i] = 8'($urandom); tbl_b[i] = 8'($urandom);
      end
      push_frame();
      pulse_req();
      wait_for(2, 400, "rand_frame_done", t2);
    end
    rand_rdy = 1'b0;

    // Edge parameters: single LED, latency 3, gap 1
    eg = 8'($urandom); er = 8'($urandom); eb = 8'($urandom);
    e.led = 0; e.data = {eg, er, eb};
    q_edge.push_back(e);
    exp_done_edge++;
    @(posedge clk); #1 upd_e = 1'b1;
    @(posedge clk); #1 upd_e = 1'b0;
    t0 = cyc;
    check("edge_busy_rise", 32'(busy_e), 1);
    wait_for(4, 20, "edge_valid", t1);
    check("edge_req_to_valid", 32'(t1 - t0), 32'(E_LAT));
    check("edge_led_zero_send", 32'(cur_e), 0);
    wait_for(5, 20, "edge_done", t2);
    check("edge_frame_len", 32'(t2 - t0), 32'(1 * (E_LAT + 1) + E_GAP));
    check("edge_led_zero_done", 32'(cur_e), 0);

    repeat (5) @(negedge clk);
    check("main_done_count", 32'(done_main), 32'(exp_done_main));
    check("edge_done_count", 32'(done_edge), 32'(exp_done_edge));
    check("main_queue_drained", 32'(q_main.size()), 0);
    check("edge_queue_drained", 32'(q_edge.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Controller that sequences the racer core's display datapath into one LED-strip frame. On each frame request it steps `current_led` from 0 to MAX_POS-1. For each pixel it waits out the display unit's read latency, captures the three 8-bit intensities as one GRB word and hands that word to the strip serializer over a valid/ready handshake. After the last pixel it enforces the strip latch gap. It sits between the racer core's `update_frame`/`current_led`/intensity ports and the WS2812 bit serializer.

## Interface
- MAX_POS, 16, number of LEDs on the strip; must be ≥1
- LED_READ_LATENCY, 1, clock cycles from a `current_led` change to valid intensities; must be ≥1
- RESET_GAP_CLK_COUNT, 2500, strip latch gap in clk cycles (50 µs at 50 MHz); must be ≥1

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- update_frame  in  1  frame request, level-sampled every cycle
- current_led  out  $clog2(MAX_POS)  pixel index presented to the display datapath
- led_green_intensity  in  8  green intensity for `current_led`
- led_red_intensity  in  8  red intensity for `current_led`
- led_blue_intensity  in  8  blue intensity for `current_led`
- pixel_data  out  24  {green, red, blue}, MSB first
- pixel_valid  out  1  pixel_data is valid
- pixel_ready  in  1  serializer accepts pixel_data
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at the end of the latch gap

## Operation
- States: IDLE, WAIT, SEND, GAP.
- IDLE:
  - If update_frame or pending is high, go to WAIT with current_led=0 and clear pending.
- WAIT:
  - current_led is held constant.
  - The latency counter runs 0..LED_READ_LATENCY-1.
  - On the last count, pixel_data is loaded with {G,R,B}, pixel_valid is set and the state moves to SEND.
- SEND:
  - pixel_valid and pixel_data are held until pixel_valid && pixel_ready.
  - On handshake with current_led < MAX_POS-1: current_led increments, pixel_valid clears, go to WAIT.
  - On handshake with current_led == MAX_POS-1: pixel_valid clears, go to GAP, gap counter loads RESET_GAP_CLK_COUNT-1.
- GAP:
  - The counter decrements to 0; at 0, frame_done pulses and the state returns to IDLE.
- Pending request:
  - update_frame high in any non-IDLE state sets a one-deep pending flag.
  - Any number of such requests collapse into one frame.
- pixel_ready while pixel_valid is low is ignored.
- current_led never exceeds MAX_POS-1; there is no wrap within a frame.
- Simultaneous events: update_frame in the frame_done cycle sets pending. The next frame starts on the following IDLE cycle.

## Timing
- Reset values: current_led=0, pixel_data=0, pixel_valid=0, busy=0, frame_done=0, pending=0, state IDLE.
- Reset asserted mid-frame aborts immediately. The next frame needs a fresh update_frame after reset releases.
- Request to first pixel_valid: update_frame sampled at edge k → WAIT from k+1 → pixel_valid high from edge k+1+LED_READ_LATENCY.
- Throughput with pixel_ready held high: LED_READ_LATENCY+1 cycles per pixel.
- Frame length with pixel_ready held high: MAX_POS·(LED_READ_LATENCY+1) + RESET_GAP_CLK_COUNT cycles from leaving IDLE to the frame_done pulse.
- Back-pressure stretches SEND without bound. No data loss; no timeout.
- busy rises the cycle after the accepted request and falls together with the frame_done pulse.

## Structure
- Package `led_frame_pkg`:
  - state enum (IDLE, WAIT, SEND, GAP)
  - GRB field offsets (G=23:16, R=15:8, B=7:0)
  - PIXEL_W=24
- Sub-module `led_frame_gap_timer`:
  - loadable down-counter, width $clog2(RESET_GAP_CLK_COUNT+1)
  - outputs `expired`
  - also reused for the WAIT latency count
- The top-level FSM, pending flag and pixel register live in `led_frame_sequencer`.

## Test plan
- Basic frame (MAX_POS=4, LATENCY=1, GAP=8, pixel_ready=1):
  - stimulus: intensities driven as G=current_led, R=0x10+current_led, B=0xA0; one update_frame pulse
  - response: pixel_data sequence 0x0010A0, 0x0111A0, 0x0212A0, 0x0313A0; frame_done exactly 16 cycles after busy rises
- Back-pressure:
  - stimulus: pixel_ready held low 5 cycles on pixel 2
  - response: pixel_valid and pixel_data 0x0212A0 stable throughout, current_led=2 throughout, no pixel skipped or duplicated
- Pending collapse:
  - stimulus: three update_frame pulses during pixel 1 and one during GAP
  - response: exactly one extra frame, starting the cycle after frame_done
- Async reset mid-SEND:
  - stimulus: reset driven low on pixel 2
  - response: all outputs 0 without a clock edge; after release, idle until a new update_frame
- Edge parameters:
  - stimulus: MAX_POS=1, LATENCY=3, GAP=1
  - response: one pixel at cycle k+4, then GAP, then frame_done; current_led stays 0
